// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Optional feature: define SERIAL_ADDER_SUB_EN to add the 'sub' port (subtract mode).
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell used by the serial datapath.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    logic w_axb;

    // Sum and carry of a single bit position
    assign w_axb = A ^ B;
    assign S     = w_axb ^ Cin;
    assign Cout  = (A & B) | (Cin & w_axb);

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial adder: loads a/b/cin, adds one bit per cycle LSB first, presents
// {cout,sum} until the consumer takes it.
// Optional feature: define SERIAL_ADDER_SUB_EN to add the 'sub' port; with sub=1
// the block computes a - b (cout=1 means no borrow).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;

    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic [WIDTH-1:0]   w_b_load;
    logic               w_c_load;
    logic               w_s;
    logic               w_co;

    // Operand conditioning at acceptance: subtract mode feeds ~b with carry 1
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub ? 1'b1 : cin;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    full_adder u_fa (
        .A    (r_a_sr[0]),
        .B    (r_b_sr[0]),
        .Cin  (r_carry),
        .S    (w_s),
        .Cout (w_co)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-cycle control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Serial datapath: load on accept, one bit per SHIFT cycle, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a_sr  <= a;
            r_b_sr  <= w_b_load;
            r_carry <= w_c_load;
            r_cnt   <= '0;
        end else if (r_state == SHIFT) begin
            r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_result <= {w_s, r_result[WIDTH-1:1]};
            r_carry  <= w_co;
            if (!w_last) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Handshake/status flags registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
            r_busy      <= (w_state_nxt == SHIFT);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_result;
    assign cout      = r_carry;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vectors, backpressure,
// mid-operation reset and randomized back-to-back traffic against a model.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif

    int total;
    int bad;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operands
    function automatic logic [W:0] ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                             input logic rcin, input logic rsub);
        longint signed s;
        logic [W:0]    r;
        if (rsub) begin
            s = longint'(ra) - longint'(rb);
            r = {(ra >= rb), W'(s)};
        end else begin
            s = longint'(ra) + longint'(rb) + longint'(rcin);
            r = (W+1)'(s);
        end
        return r;
    endfunction

    task automatic randomize_inputs();
        in_valid = 1'($urandom);
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
        sub      = 1'($urandom);
`endif
    endtask

    // Runs one operation; garbage is driven on the inputs while busy/done
    task automatic drive_op(input logic [W-1:0] ta, input logic [W-1:0] tb_op, input logic tcin,
                            input logic tsub, input bit rand_ready,
                            output logic [W-1:0] s_first, output logic c_first,
                            output logic [W-1:0] s_last, output logic c_last,
                            output int lat, output bit tmo);
        int n;
        bit hs;
        tmo     = 1'b0;
        lat     = 0;
        s_first = '0;
        c_first = 1'b0;
        s_last  = '0;
        c_last  = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            tmo = 1'b1;
            return;
        end
        a        = ta;
        b        = tb_op;
        cin      = tcin;
        in_valid = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub      = tsub;
`else
        if (tsub) tmo = 1'b1;
`endif
        tick();
        while (!out_valid && lat < 100) begin
            randomize_inputs();
            tick();
            lat++;
        end
        if (!out_valid) begin
            in_valid = 1'b0;
            tmo      = 1'b1;
            return;
        end
        s_first = sum;
        c_first = cout;
        n  = 0;
        hs = 1'b0;
        while (!hs) begin
            out_ready = (rand_ready && n < 50) ? 1'($urandom) : 1'b1;
            if (out_ready) begin
                in_valid = 1'b0;
            end else begin
                randomize_inputs();
            end
            hs     = out_ready;
            s_last = sum;
            c_last = cout;
            tick();
            n++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++;
        if (sum !== '0) begin bad++; $display("FAIL reset_sum: got %h want 00", sum); end
        total++;
        if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b want 0", cout); end
        total++;
    endtask

    task automatic test_directed();
        logic [W-1:0] va [3];
        logic [W-1:0] vb [3];
        logic         vc [3];
        logic [W-1:0] es [3];
        logic         ec [3];
        logic [W-1:0] s0, s1;
        logic         c0, c1;
        int           lat;
        bit           tmo;
        va[0] = 8'h0F; vb[0] = 8'h01; vc[0] = 1'b0; es[0] = 8'h10; ec[0] = 1'b0;
        va[1] = 8'hFF; vb[1] = 8'h01; vc[1] = 1'b0; es[1] = 8'h00; ec[1] = 1'b1;
        va[2] = 8'hFF; vb[2] = 8'hFF; vc[2] = 1'b1; es[2] = 8'hFF; ec[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_op(va[i], vb[i], vc[i], 1'b0, 1'b0, s0, c0, s1, c1, lat, tmo);
            total++;
            if (tmo) begin bad++; $display("FAIL directed_timeout[%0d]: got timeout want result", i); end
            total++;
            if ({c0, s0} !== {ec[i], es[i]}) begin
                bad++; $display("FAIL directed_result[%0d]: got cout=%b sum=%h want cout=%b sum=%h", i, c0, s0, ec[i], es[i]);
            end
            total++;
            if (lat !== int'(W)) begin bad++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, W); end
        end
    endtask

    task automatic test_backpressure();
        logic [W:0] exp;
        int         n;
        exp = ref_model(8'h3C, 8'h4B, 1'b1, 1'b0);
        a = 8'h3C; b = 8'h4B; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        tick();
        in_valid = 1'b0;
        total++;
        if ({busy, in_ready, out_valid} !== 3'b100) begin
            bad++; $display("FAIL bp_shift_flags: got busy/in_ready/out_valid=%b want 100", {busy, in_ready, out_valid});
        end
        n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        total++;
        if (!out_valid) begin bad++; $display("FAIL bp_wait_done: got out_valid=0 want 1"); end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
            cin = 1'($urandom);
            tick();
            total++;
            if ({out_valid, in_ready, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, exp}) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got ov=%b ir=%b busy=%b cout=%b sum=%h want ov=1 ir=0 busy=0 cout=%b sum=%h",
                         i, out_valid, in_ready, busy, cout, sum, exp[W], exp[W-1:0]);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++; $display("FAIL bp_release: got out_valid/in_ready=%b want 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_reset_midshift();
        logic [W-1:0] s0, s1;
        logic         c0, c1;
        int           lat;
        bit           tmo;
        a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, W'(0)}) begin
            bad++;
            $display("FAIL midshift_reset: got ir=%b ov=%b busy=%b cout=%b sum=%h want ir=1 ov=0 busy=0 cout=0 sum=00",
                     in_ready, out_valid, busy, cout, sum);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        drive_op(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, s0, c0, s1, c1, lat, tmo);
        total++;
        if (tmo || {c0, s0} !== {1'b0, 8'h03}) begin
            bad++; $display("FAIL post_reset_op: got tmo=%b cout=%b sum=%h want cout=0 sum=03", tmo, c0, s0);
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_subtract();
        logic [W-1:0] s0, s1;
        logic         c0, c1;
        int           lat;
        bit           tmo;
        drive_op(8'h05, 8'h07, 1'b1, 1'b1, 1'b0, s0, c0, s1, c1, lat, tmo);
        total++;
        if (tmo || {c0, s0} !== {1'b0, 8'hFE}) begin
            bad++; $display("FAIL sub_5_7: got cout=%b sum=%h want cout=0 sum=fe", c0, s0);
        end
        drive_op(8'h07, 8'h05, 1'b0, 1'b1, 1'b0, s0, c0, s1, c1, lat, tmo);
        total++;
        if (tmo || {c0, s0} !== {1'b1, 8'h02}) begin
            bad++; $display("FAIL sub_7_5: got cout=%b sum=%h want cout=1 sum=02", c0, s0);
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [W-1:0] ta, tb_op, s0, s1;
        logic         tc, ts, c0, c1;
        logic [W:0]   exp;
        int           lat;
        bit           tmo;
        for (int i = 0; i < 1000; i++) begin
            ta    = W'($urandom);
            tb_op = W'($urandom);
            tc    = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            ts    = 1'($urandom);
`else
            ts    = 1'b0;
`endif
            exp = ref_model(ta, tb_op, tc, ts);
            drive_op(ta, tb_op, tc, ts, 1'b1, s0, c0, s1, c1, lat, tmo);
            total++;
            if (tmo) begin
                bad++; $display("FAIL b2b_timeout[%0d]: got timeout want result", i);
                break;
            end
            total++;
            if ({c0, s0} !== exp) begin
                bad++;
                $display("FAIL b2b_result[%0d]: a=%h b=%h cin=%b sub=%b got cout=%b sum=%h want cout=%b sum=%h",
                         i, ta, tb_op, tc, ts, c0, s0, exp[W], exp[W-1:0]);
            end
            total++;
            if ({c1, s1} !== {c0, s0} || lat !== int'(W)) begin
                bad++;
                $display("FAIL b2b_stable[%0d]: got last=%b/%h lat=%0d want first=%b/%h lat=%0d",
                         i, c1, s1, lat, c0, s0, W);
            end
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub       = 1'b0;
`endif
        #12;
        test_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        test_directed();
        test_backpressure();
        test_reset_midshift();
`ifdef SERIAL_ADDER_SUB_EN
        test_subtract();
`endif
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_adder
